// File: rtl/doc_pkg.sv
// doc_pkg
// Shared definitions for the document export path: document geometry,
// the ASCII control/substitute characters used on the serial stream, and
// the export sequencer state encoding.
package doc_pkg;

  localparam int DOC_ROWS     = 15;
  localparam int DOC_COLS     = 20;
  localparam int DOC_ROW_BITS = 4;
  localparam int DOC_COL_BITS = 5;

  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CAPT,
    ST_SEND,
    ST_CR,
    ST_LF,
    ST_FIN
  } exp_state_t;

endpackage

// File: rtl/char_to_ascii.sv
// char_to_ascii
// Maps a 7-bit document character code to a printable 8-bit byte.
// An empty cell (0x00) becomes a space, printable codes 0x20..0x7E pass
// through, and control codes / DEL become '?' so the terminal never sees
// raw control characters from the document.
// Ports:
//   code_i  [6:0]  character code from the document RAM
//   ascii_o [7:0]  byte to transmit
module char_to_ascii
  import doc_pkg::*;
(
  input  logic [6:0] code_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = ASCII_QMARK;
    if (code_i == 7'h00) begin
      ascii_o = ASCII_SP;
    end else if ((code_i >= 7'h20) && (code_i != 7'h7F)) begin
      ascii_o = {1'b0, code_i};
    end
  end

endmodule

// File: rtl/doc_export_sequencer.sv
// doc_export_sequencer
// Walks the document RAM in row-major order and streams every cell as an
// ASCII byte over a valid/ready handshake, optionally terminating each row
// with CR LF and optionally pulsing clear_data once the export completes.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      single-cycle export request / cancel
//   doc_data          document read data for doc_addr
//   doc_read_enable   high while the sequencer owns the document read port
//   doc_addr          {row, col} document address
//   tx_data/tx_valid  byte stream towards the UART transmitter
//   tx_ready          transmitter accepts the byte this cycle
//   clear_data        one-cycle pulse after a completed export
//   busy              export in progress
module doc_export_sequencer
  import doc_pkg::*;
#(
  parameter int ROWS        = DOC_ROWS,
  parameter int COLS        = DOC_COLS,
  parameter int ROW_BITS    = DOC_ROW_BITS,
  parameter int COL_BITS    = DOC_COL_BITS,
  parameter bit EMIT_CRLF   = 1'b1,
  parameter bit CLEAR_AFTER = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [7:0]                   doc_data,
  output logic                         doc_read_enable,
  output logic [ROW_BITS+COL_BITS-1:0] doc_addr,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         clear_data,
  output logic                         busy
);

  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);

  exp_state_t          state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                rd_en_q, rd_en_d;
  logic                clear_q, clear_d;
  logic                busy_q, busy_d;

  logic [7:0] mapped_byte;
  logic       doc_msb_unused;

  // Bit 7 of the document word carries no character information.
  assign doc_msb_unused = doc_data[7];

  char_to_ascii u_map (
    .code_i  (doc_data[6:0]),
    .ascii_o (mapped_byte)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    valid_d = valid_q;
    rd_en_d = rd_en_q;
    clear_d = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          row_d   = '0;
          col_d   = '0;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_ADDR;
        end
      end
      // The address was registered on entry, so the RAM sees it during
      // ADDR; a synchronous RAM then returns data during CAPT.
      ST_ADDR: state_d = ST_CAPT;
      ST_CAPT: begin
        data_d  = mapped_byte;
        valid_d = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          valid_d = 1'b0;
          if (col_q != COL_LAST) begin
            col_d   = col_q + 1'b1;
            state_d = ST_ADDR;
          end else if (EMIT_CRLF) begin
            data_d  = ASCII_CR;
            valid_d = 1'b1;
            state_d = ST_CR;
          end else if (row_q != ROW_LAST) begin
            row_d   = row_q + 1'b1;
            col_d   = '0;
            state_d = ST_ADDR;
          end else begin
            rd_en_d = 1'b0;
            clear_d = CLEAR_AFTER;
            state_d = ST_FIN;
          end
        end
      end
      ST_CR: begin
        if (tx_ready) begin
          data_d  = ASCII_LF;
          state_d = ST_LF;
        end
      end
      ST_LF: begin
        if (tx_ready) begin
          valid_d = 1'b0;
          if (row_q != ROW_LAST) begin
            row_d   = row_q + 1'b1;
            col_d   = '0;
            state_d = ST_ADDR;
          end else begin
            rd_en_d = 1'b0;
            clear_d = CLEAR_AFTER;
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Cancel overrides everything, including a byte mid-handshake.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      row_d   = '0;
      col_d   = '0;
      valid_d = 1'b0;
      rd_en_d = 1'b0;
      clear_d = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      rd_en_q <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rd_en_q <= rd_en_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
    end
  end

  // row/col are registers, so the address output is registered as well.
  assign doc_addr        = {row_q, col_q};
  assign doc_read_enable = rd_en_q;
  assign tx_data         = data_q;
  assign tx_valid        = valid_q;
  assign clear_data      = clear_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_doc_export_sequencer.sv
module tb_doc_export_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic tx_ready = 1'b1;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] mem [0:511];

  // Instance A: defaults, synchronous-read document RAM
  logic       rden_a, txv_a, clr_a, busy_a;
  logic [8:0] addr_a;
  logic [7:0] txd_a;
  logic [7:0] doc_data_a;
  logic       start_a, abort_a;
  assign start_a = start & ~sel;
  assign abort_a = abort & ~sel;
  always @(posedge clk) if (rden_a) doc_data_a <= mem[addr_a];

  doc_export_sequencer dut (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .doc_data(doc_data_a), .doc_read_enable(rden_a), .doc_addr(addr_a),
    .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(tx_ready),
    .clear_data(clr_a), .busy(busy_a)
  );

  // Instance B: CLEAR_AFTER=1, asynchronous-read document RAM
  logic       rden_b, txv_b, clr_b, busy_b;
  logic [8:0] addr_b;
  logic [7:0] txd_b;
  logic [7:0] doc_data_b;
  logic       start_b, abort_b;
  assign start_b = start & sel;
  assign abort_b = abort & sel;
  assign doc_data_b = mem[addr_b];

  doc_export_sequencer #(.CLEAR_AFTER(1'b1)) dut_clr (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .doc_data(doc_data_b), .doc_read_enable(rden_b), .doc_addr(addr_b),
    .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(tx_ready),
    .clear_data(clr_b), .busy(busy_b)
  );

  logic       m_rden, m_txv, m_clr, m_busy;
  logic [8:0] m_addr;
  logic [7:0] m_txd;
  assign m_rden = sel ? rden_b : rden_a;
  assign m_txv  = sel ? txv_b  : txv_a;
  assign m_clr  = sel ? clr_b  : clr_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_addr = sel ? addr_b : addr_a;
  assign m_txd  = sel ? txd_b  : txd_a;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx [0:511];
  int n_rx, clr_seen, clr_cyc, last_hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model(input logic [7:0] raw);
    logic [6:0] c;
    c = raw[6:0];
    if (c == 7'd0) return 8'h20;
    if (c < 7'h20 || c == 7'h7F) return 8'h3F;
    return {1'b0, c};
  endfunction

  task automatic push_expected();
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 20; c++) exp_q.push_back(model(mem[r * 32 + c]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic start_export();
    push_expected();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_busy", m_busy, 1);
    check("start_rden", m_rden, 1);
    check("start_addr", m_addr, 0);
    check("start_valid", m_txv, 0);
  endtask

  // Samples at negedge; a transfer happens at the next posedge when
  // tx_valid is seen high and tx_ready is driven high here.
  task automatic collect(input int stall_at, input int abort_at, input int restart_at, input int budget);
    int cyc = 0;
    int stall = 0;
    bit done = 0;
    bit restarted = 0;
    logic [7:0] hd, e;
    logic [8:0] ha;
    n_rx = 0; clr_seen = 0; clr_cyc = -1; last_hs = -1;
    while (!done && cyc < budget) begin
      @(negedge clk); cyc++;
      start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
      if (m_clr) begin clr_seen++; clr_cyc = cyc; end
      if (!m_busy) done = 1;
      else begin
        if (n_rx == restart_at && m_txv && !restarted) begin
          start = 1'b1; restarted = 1;
        end
        if (n_rx == abort_at && m_txv) begin
          abort = 1'b1; tx_ready = 1'b0;
        end else if (n_rx == stall_at && m_txv && stall < 7) begin
          tx_ready = 1'b0;
          if (stall == 0) begin
            hd = m_txd; ha = m_addr;
          end else begin
            check("stall_valid", m_txv, 1);
            check("stall_data", m_txd, hd);
            check("stall_addr", m_addr, ha);
          end
          stall++;
        end
        if (m_txv && tx_ready) begin
          if (exp_q.size() == 0) check("unexpected_byte", n_rx, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            check("stream_byte", m_txd, e);
          end
          rx[n_rx] = m_txd; n_rx++; last_hs = cyc;
        end
      end
    end
    check("export_done", done, 1);
  endtask

  initial begin
    bit seen_tx;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0]       = 8'h41;
    mem[1]       = 8'h00;
    mem[2]       = 8'h05;
    mem[14*32+19] = 8'h7A;
    mem[32]      = 8'hC1;
    mem[33]      = 8'h7F;
    mem[34]      = 8'h7E;
    mem[35]      = 8'h1F;
    mem[36]      = 8'h20;

    // reset state
    @(negedge clk); @(negedge clk);
    check("rst_valid", txv_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_rden", rden_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_data", txd_a, 0);
    check("rst_clear", clr_a, 0);
    rst = 1'b0;

    // start and abort together while idle: stays idle
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy_a, 0);
    check("start_abort_rden", rden_a, 0);

    // full export, tx_ready held high
    start_export();
    collect(-1, -1, -1, 2000);
    check("full_count", n_rx, 330);
    check("full_queue_empty", exp_q.size(), 0);
    check("full_no_clear", clr_seen, 0);
    check("full_busy_end", m_busy, 0);
    check("byte0", rx[0], 8'h41);
    check("byte1", rx[1], 8'h20);
    check("byte2", rx[2], 8'h3F);
    check("byte20_cr", rx[20], 8'h0D);
    check("byte21_lf", rx[21], 8'h0A);
    check("byte22_msb", rx[22], 8'h41);
    check("byte327", rx[327], 8'h7A);
    check("byte328", rx[328], 8'h0D);
    check("byte329", rx[329], 8'h0A);

    // backpressure on byte 5
    start_export();
    collect(5, -1, -1, 2000);
    check("bp_count", n_rx, 330);
    check("bp_queue_empty", exp_q.size(), 0);

    // abort during byte 100
    start_export();
    collect(-1, 100, -1, 2000);
    check("abort_valid", m_txv, 0);
    check("abort_busy", m_busy, 0);
    check("abort_no_clear", clr_seen, 0);
    check("abort_count", n_rx, 100);
    exp_q.delete();

    // restart after abort begins at address 0
    start_export();
    collect(-1, -1, -1, 2000);
    check("restart_count", n_rx, 330);
    check("restart_byte0", rx[0], 8'h41);

    // CLEAR_AFTER=1 instance, start while busy ignored
    sel = 1'b1;
    start_export();
    collect(-1, -1, 50, 2000);
    check("clr_count", n_rx, 330);
    check("clr_queue_empty", exp_q.size(), 0);
    check("clr_pulses", clr_seen, 1);
    check("clr_timing", clr_cyc, last_hs + 1);
    exp_q.delete();

    // asynchronous reset while holding a byte in SEND
    sel = 1'b0;
    @(negedge clk); tx_ready = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !m_txv; i++) @(negedge clk);
    check("arst_setup_valid", m_txv, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", txv_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_rden", rden_a, 0);
    check("arst_addr", addr_a, 0);
    check("arst_data", txd_a, 0);
    check("arst_clear", clr_a, 0);
    @(negedge clk); rst = 1'b0; tx_ready = 1'b1;
    seen_tx = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txv_a || busy_a) seen_tx = 1;
    end
    check("arst_stays_idle", seen_tx, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/doc_export_sequencer.md
Name: doc_export_sequencer

Overview:
Sequences a full read-out of the document RAM (15 rows x 20 cols of 7-bit character codes) and streams it as ASCII bytes to the UART transmitter over a valid/ready handshake.
- Sits between the text editor's document read port (read_enable / read_out_addr / spo) and uart_tx.
- Triggered by the debounced, one-pulsed send_data button.
- Optionally pulses clear_data to the text editor after the last byte is accepted.

Parameters:
ROWS, 15, number of text rows exported (row index 0..ROWS-1)
COLS, 20, characters per row (col index 0..COLS-1)
ROW_BITS, 4, row field width of document address
COL_BITS, 5, col field width of document address
EMIT_CRLF, 1, 1 = append 0x0D 0x0A after each row
CLEAR_AFTER, 0, 1 = pulse clear_data on completion

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle request to begin export
abort  in  1  single-cycle request to cancel export
doc_data  in  8  document read data for doc_addr
doc_read_enable  out  1  high while the sequencer owns the document read port
doc_addr  out  9  {row[ROW_BITS-1:0], col[COL_BITS-1:0]}
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte this cycle
clear_data  out  1  one-cycle pulse after a completed export (CLEAR_AFTER=1 only)
busy  out  1  export in progress

Behaviour:
- Clock and reset are fixed: one clock, clk; rst is asynchronous, active-high.
- Reset values: state IDLE, row=0, col=0, doc_read_enable=0, doc_addr=0, tx_data=0, tx_valid=0, clear_data=0, busy=0.
- All outputs are registered.
- FSM states: IDLE, ADDR, CAPT, SEND, CR, LF, FIN.
- IDLE:
  - start=1 -> row=0, col=0, ADDR.
  - busy and doc_read_enable assert the cycle after start.
- ADDR:
  - drive doc_addr={row,col} with doc_read_enable=1, go to CAPT.
  - doc_data is sampled one cycle after the address is presented. This covers both async and registered RAM reads.
- CAPT: map doc_data[6:0] to a byte, load tx_data, set tx_valid=1, go to SEND. Mapping:
  - 0x00 -> 0x20 (blank cell).
  - 0x20..0x7E -> unchanged.
  - any other value (0x01..0x1F, 0x7F) -> 0x3F '?'.
  - doc_data[7] is ignored.
- SEND: hold tx_valid and tx_data stable until tx_ready=1. On the handshake cycle:
  - if col<COLS-1: col++, ADDR.
  - else if EMIT_CRLF: CR.
  - else if row<ROWS-1: row++, col=0, ADDR.
  - else: FIN.
- tx_ready=1 in the same cycle tx_valid rises counts as a transfer. No combinational path from tx_ready to tx_valid.
- CR: tx_data=0x0D, tx_valid=1; on handshake go to LF.
- LF: tx_data=0x0A, tx_valid=1; on handshake:
  - row<ROWS-1 -> row++, col=0, ADDR.
  - else FIN.
- FIN: tx_valid=0, doc_read_enable=0, clear_data=CLEAR_AFTER for exactly one cycle, then IDLE. busy deasserts on entry to IDLE.
- Throughput: minimum 3 cycles per character byte (ADDR, CAPT, SEND with tx_ready high); CR/LF 1 cycle each.
- Byte count per export: ROWS*(COLS+2*EMIT_CRLF); 330 at defaults.
- start while busy: ignored.
- abort in any non-IDLE state:
  - go to IDLE next cycle, dropping tx_valid even mid-handshake.
  - no clear_data pulse.
- abort and start in the same cycle while IDLE: abort wins, stay IDLE.
- Async rst mid-export: immediate return to reset values; no clear_data.
- row/col counters never exceed ROWS-1/COLS-1. Addresses for col>=COLS are never issued.

Decomposition:
- Shared package doc_pkg:
  - DOC_ROWS, DOC_COLS, DOC_ROW_BITS, DOC_COL_BITS.
  - ASCII_SP, ASCII_CR, ASCII_LF, ASCII_QMARK.
  - state typedef/localparams for the export FSM.
- One natural combinational sub-module, char_to_ascii: 7-bit code -> 8-bit byte mapping, reused later by the receive path.

Test Plan:
- Reset and idle: defaults, tx_ready tied 1, start pulse -> exactly 330 bytes, in row-major order, every 20th byte followed by 0x0D 0x0A; then clear_data stays 0; busy low after the last LF.
- Content and mapping: doc cell (0,0)=0x41, (0,1)=0x00, (0,2)=0x05, (14,19)=0x7A. Required stream: bytes 0..2 = 0x41, 0x20, 0x3F; the 328th byte = 0x7A, followed by 0x0D, 0x0A.
- Backpressure: tx_ready low for 7 cycles on byte 5 -> tx_valid and tx_data unchanged throughout; no byte lost or duplicated; doc_addr not advanced.
- Abort: abort during byte 100 -> tx_valid=0 and busy=0 the next cycle; no clear_data; a subsequent start restarts at address 0.
- Start while busy and CLEAR_AFTER=1: second start mid-export ignored (byte count stays 330); clear_data high exactly one cycle after the final LF handshake.
- Async rst asserted mid-SEND, off a clock edge: outputs return to reset values immediately; no further tx_valid until a new start.
